mac_v4: RTL and testbench



---
 rtl/mac_v4_pkg.sv | 16 +
 rtl/mac_v4_mult.sv | 18 +
 rtl/mac_v4.sv | 73 +++++++
 tb/tb_mac_v4.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_v4_pkg.sv
// rtl/mac_v4_pkg.sv - shared widths, constants and types for the mac_v4 multiply-accumulate unit
package mac_v4_pkg;

  localparam int IN_W          = 4;
  localparam int OUT_W         = 10;
  localparam int NUM_TERMS_DEF = 4;
  localparam int CNT_W         = 4;

  localparam logic [OUT_W-1:0] SAT_VAL = 10'd1023;

  typedef logic [IN_W-1:0]   operand_t;
  typedef logic [2*IN_W-1:0] product_t;
  typedef logic [OUT_W-1:0]  acc_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/mac_v4_mult.sv
// rtl/mac_v4_mult.sv - combinational unsigned IN_W x IN_W multiplier
module mac_v4_mult
  import mac_v4_pkg::*;
(
  input  logic [IN_W-1:0]   i_a,
  input  logic [IN_W-1:0]   i_b,
  output logic [2*IN_W-1:0] o_prod
);

  product_t w_a_ext;
  product_t w_b_ext;

  // Operands are widened first so the product keeps its full 2*IN_W bits.
  assign w_a_ext = {{IN_W{1'b0}}, i_a};
  assign w_b_ext = {{IN_W{1'b0}}, i_b};
  assign o_prod  = w_a_ext * w_b_ext;

endmodule

// File: rtl/mac_v4.sv
// rtl/mac_v4.sv - windowed unsigned MAC; define MAC_V4_SAT_EN for saturating accumulation
module mac_v4
  import mac_v4_pkg::*;
#(
  parameter int NUM_TERMS = NUM_TERMS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in1_IFM,
  input  logic [IN_W-1:0]  in2_IFM,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out,
  output logic             out_valid
);

  localparam cnt_t LAST_CNT = cnt_t'(NUM_TERMS - 1);

  acc_t     r_acc;
  cnt_t     r_cnt;
  acc_t     r_out;
  logic     r_out_valid;

  product_t w_prod;
  acc_t     w_prod_ext;
  acc_t     w_sum;
  logic     w_last;

  mac_v4_mult u_mult (
    .i_a    (in1_IFM),
    .i_b    (in2_IFM),
    .o_prod (w_prod)
  );

  assign w_prod_ext = {{(OUT_W - 2*IN_W){1'b0}}, w_prod};
  assign w_last     = (r_cnt == LAST_CNT);

`ifdef MAC_V4_SAT_EN
  logic [OUT_W:0] w_sum_wide;

  // Carry out of the accumulator clamps to full scale; a clamped acc stays
  // clamped because any further carry clamps again.
  assign w_sum_wide = {1'b0, r_acc} + {1'b0, w_prod_ext};
  assign w_sum      = w_sum_wide[OUT_W] ? SAT_VAL : w_sum_wide[OUT_W-1:0];
`else
  assign w_sum = r_acc + w_prod_ext;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (in_valid) begin
        if (w_last) begin
          r_out       <= w_sum;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + cnt_t'(1);
        end
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mac_v4.sv
// tb/tb_mac_v4.sv - self-checking bench for mac_v4 (windows of 4 and 8 terms)
module tb_mac_v4;

`ifdef MAC_V4_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] in1;
  logic [3:0] in2;
  logic       vld;
  logic [9:0] out4;
  logic       ov4;
  logic [9:0] out8;
  logic       ov8;

  mac_v4 #(.NUM_TERMS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in1_IFM(in1), .in2_IFM(in2), .in_valid(vld),
    .out(out4), .out_valid(ov4)
  );

  mac_v4 #(.NUM_TERMS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in1_IFM(in1), .in2_IFM(in2), .in_valid(vld),
    .out(out8), .out_valid(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: per-instance list of products accepted in the open window.
  int m_n[2] = '{4, 8};
  int m_terms[2][$];
  int m_out[2];
  bit m_ov[2];

  typedef struct {
    bit v;
    int a;
    int b;
    int eo;
    bit ev;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int window_sum(input int terms[$]);
    int s = 0;
    foreach (terms[i]) begin
      s += terms[i];
      if (SAT && s > 1023) s = 1023;
    end
    return SAT ? s : s % 1024;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_terms[k].delete();
      m_out[k] = 0;
      m_ov[k]  = 1'b0;
    end
  endtask

  task automatic model_edge(input bit v, input int a, input int b);
    for (int k = 0; k < 2; k++) begin
      m_ov[k] = 1'b0;
      if (v) begin
        m_terms[k].push_back(a * b);
        if (m_terms[k].size() == m_n[k]) begin
          m_out[k] = window_sum(m_terms[k]);
          m_ov[k]  = 1'b1;
          m_terms[k].delete();
        end
      end
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, " out4"}, int'(out4), m_out[0]);
    chk({tag, " ov4"},  int'(ov4),  int'(m_ov[0]));
    chk({tag, " out8"}, int'(out8), m_out[1]);
    chk({tag, " ov8"},  int'(ov8),  int'(m_ov[1]));
  endtask

  // Called 2 time units after a posedge; samples again 2 units after the next one.
  task automatic step(input bit v, input int a, input int b);
    vld = v;
    in1 = 4'(a);
    in2 = 4'(b);
    @(posedge clk);
    model_edge(v, a, b);
    #2;
  endtask

  task automatic full_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    vld   = 1'b0;
    in1   = '0;
    in2   = '0;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;

    // Reset held with live inputs must keep everything cleared.
    for (int i = 0; i < 4; i++) begin
      vld = 1'b1;
      in1 = 4'($urandom);
      in2 = 4'($urandom);
      @(posedge clk);
      #2;
      chk("reset out4", int'(out4), 0);
      chk("reset ov4", int'(ov4), 0);
      chk("reset out8", int'(out8), 0);
    end
    vld   = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 0, 0);
    chk("post-reset out4", int'(out4), 0);
    chk("post-reset ov4", int'(ov4), 0);

    // Basic window then gapped window.
    tbl.push_back('{1, 1, 2, 0, 0});
    tbl.push_back('{1, 3, 4, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 14, 1});
    tbl.push_back('{0, 9, 9, 14, 0});
    tbl.push_back('{0, 0, 0, 14, 0});
    tbl.push_back('{1, 1, 2, 14, 0});
    tbl.push_back('{0, 7, 7, 14, 0});
    tbl.push_back('{1, 3, 4, 14, 0});
    tbl.push_back('{0, 0, 0, 14, 0});
    tbl.push_back('{0, 15, 15, 14, 0});
    tbl.push_back('{1, 5, 5, 14, 0});
    tbl.push_back('{1, 2, 3, 45, 1});
    tbl.push_back('{0, 0, 0, 45, 0});
    tbl.push_back('{0, 0, 0, 45, 0});
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].a, tbl[i].b);
      chk($sformatf("vec%0d out", i), int'(out4), tbl[i].eo);
      chk($sformatf("vec%0d out_valid", i), int'(ov4), int'(tbl[i].ev));
      model_check($sformatf("vec%0d model", i));
    end

    // Max operands, then a back-to-back window with no bubble.
    full_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 15, 15);
    chk("max out", int'(out4), 900);
    chk("max out_valid", int'(ov4), 1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1, 1);
      chk($sformatf("b2b out_valid c%0d", i), int'(ov4), (i == 3) ? 1 : 0);
    end
    chk("b2b out", int'(out4), 4);
    model_check("b2b");

    // Asynchronous reset between edges discards the partial window.
    step(1'b1, 7, 7);
    step(1'b1, 7, 7);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async reset out4", int'(out4), 0);
    chk("async reset ov4", int'(ov4), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 2, 2);
    chk("after reset out", int'(out4), 16);
    chk("after reset out_valid", int'(ov4), 1);
    step(1'b0, 0, 0);
    chk("strobe one cycle", int'(ov4), 0);
    chk("out holds", int'(out4), 16);

    // Eight full-scale pairs overflow a window of 8.
    full_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 15, 15);
    chk("overflow out8", int'(out8), SAT ? 1023 : 776);
    chk("overflow ov8", int'(ov8), 1);
    model_check("overflow");

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      model_check($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
